// File: rtl/n_bit_hierarchical_ling_cla_pkg.sv
// Shared constants for the hierarchical Ling carry-lookahead adder.
//   GROUP_SIZE    : fan-in of every look-ahead group (fixed at 4)
//   DEFAULT_WIDTH : default operand width of the adder
package n_bit_hierarchical_ling_cla_pkg;
  localparam int GROUP_SIZE    = 4;
  localparam int DEFAULT_WIDTH = 64;
endpackage

// File: rtl/n_bit_hierarchical_ling_cla_group4.sv
// ling_group4: one 4-element Ling look-ahead group, reused at every level.
// Each element k obeys h[k] = g[k] | (t[k] & h[k-1]), with h[-1] = hin.
// At the bit level t[k] is the transmit of the bit *below* element k.
// At upper levels g/t are the group pseudo-generate/transmit of sub-groups.
// Ports:
//   g[3:0], t[3:0] : element generate / transmit
//   hin            : pseudo-carry entering the group
//   h[3:0]         : pseudo-carry after each element (flattened, no ripple)
//   gg, gt         : group pseudo-generate and group transmit
module ling_group4 (
  input  logic [3:0] g,
  input  logic [3:0] t,
  input  logic       hin,
  output logic [3:0] h,
  output logic       gg,
  output logic       gt
);

  always_comb begin
    gg   = g[3] | (t[3] & g[2]) | (t[3] & t[2] & g[1]) | (t[3] & t[2] & t[1] & g[0]);
    gt   = &t;
    h[0] = g[0] | (t[0] & hin);
    h[1] = g[1] | (t[1] & g[0]) | (t[1] & t[0] & hin);
    h[2] = g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0]) | (t[2] & t[1] & t[0] & hin);
    h[3] = gg | (gt & hin);
  end

endmodule

// File: rtl/n_bit_hierarchical_ling_cla.sv
// n_bit_hierarchical_ling_cla: N-bit adder using Ling pseudo-carries computed
// by a tree of 4-wide look-ahead groups, with a registered sum/carry-out.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears s and cout
//   a, b : unsigned N-bit operands
//   cin  : carry-in
//   s    : registered sum, 1-cycle latency
//   cout : registered carry-out
// Interface: no valid/ready handshake. A new operand set is taken on every
// rising edge and its result appears on s/cout after that same edge.
module n_bit_hierarchical_ling_cla
  import n_bit_hierarchical_ling_cla_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  // Number of tree levels so that 4^LEVELS covers N; the leaf level is padded
  // to NP bits with g = t = 0, and the padded outputs are never consumed.
  localparam int LEVELS = ($clog2(N) + 1) / 2;
  localparam int NP     = 1 << (2 * LEVELS);

  logic [N-1:0]  p, g, t;
  logic [NP-1:0] g_pad, ts_pad;
  logic [N:1]    h;
  logic [N-1:0]  s_next;
  logic          cout_next;

  // Stage 1: bitwise propagate / generate / transmit.
  always_comb begin : gp_generation
    p = a ^ b;
    g = a & b;
    t = a | b;
  end

  // Leaf inputs: element i pairs g[i] with t[i-1]. Element 0 has no lower
  // bit, so its transmit is 1 and cin acts as the incoming pseudo-carry,
  // giving h[1] = g[0] | cin.
  always_comb begin
    g_pad          = '0;
    ts_pad         = '0;
    g_pad[N-1:0]   = g;
    ts_pad[0]      = 1'b1;
    ts_pad[N-1:1]  = t[N-2:0];
  end

  // Stage 2: look-ahead tree. Upward, each level's gg/gt feed the next level.
  // Downward, group j of a level takes its pseudo-carry from the parent's
  // output just before it (parent element j-1); group 0 always takes cin.
  for (genvar l = 0; l < LEVELS; l++) begin : lv
    localparam int NG = NP >> (2 * (l + 1));
    logic [GROUP_SIZE*NG-1:0] gin, tin, hout;
    logic [NG-1:0]            gg, gt, hin;

    if (l == 0) begin : g_leaf
      assign gin = g_pad;
      assign tin = ts_pad;
    end else begin : g_node
      assign gin = lv[l-1].gg;
      assign tin = lv[l-1].gt;
    end

    for (genvar j = 0; j < NG; j++) begin : g_hin
      if (j == 0) begin : g_first
        assign hin[j] = cin;
      end else begin : g_rest
        assign hin[j] = lv[l+1].hout[j-1];
      end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
      ling_group4 u_grp (
        .g   (gin[GROUP_SIZE*k +: GROUP_SIZE]),
        .t   (tin[GROUP_SIZE*k +: GROUP_SIZE]),
        .hin (hin[k]),
        .h   (hout[GROUP_SIZE*k +: GROUP_SIZE]),
        .gg  (gg[k]),
        .gt  (gt[k])
      );
    end

    // Last group output of each level and the root gg/gt have no consumer.
    logic unused_level;
    assign unused_level = ^{hout, gg, gt};
  end

  assign h = lv[0].hout[N-1:0];

  // Stage 3: true carry c[i] = t[i-1] & h[i], c[0] = cin.
  always_comb begin : sum_generator
    s_next[0] = p[0] ^ cin;
    for (int i = 1; i < N; i++) begin
      s_next[i] = p[i] ^ (t[i-1] & h[i]);
    end
    cout_next = h[N] & t[N-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= s_next;
      cout <= cout_next;
    end
  end

endmodule

// File: tb/tb_n_bit_hierarchical_ling_cla.sv
module tb_n_bit_hierarchical_ling_cla;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [63:0] a, b, s;
  logic        cin, cout;
  logic [7:0]  a8, b8, s8;
  logic        cin8, cout8;

  n_bit_hierarchical_ling_cla #(.N(64)) dut64 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s), .cout(cout)
  );

  n_bit_hierarchical_ling_cla #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .s(s8), .cout(cout8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [64:0] exp_q[$];
  logic [8:0]  exp8_q[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Drive on the falling edge, then sample 1 time unit after the next
  // rising edge, which is the edge that registers these inputs.
  task automatic apply(input logic [63:0] va, input logic [63:0] vb,
                       input logic vc, input logic vr);
    @(negedge clk);
    a = va; b = vb; cin = vc; rst = vr;
    @(posedge clk);
    #1;
  endtask

  task automatic apply8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a8 = va; b8 = vb; cin8 = vc; rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a = '1; b = '1; cin = 1'b1;
    a8 = '1; b8 = '1; cin8 = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset64", {cout, s}, 65'h0);
    chk("reset8", {56'h0, cout8, s8}, 65'h0);

    apply(64'd15, 64'd10, 1'b0, 1'b0);
    chk("15+10", {cout, s}, 65'd25);
    apply(64'd15, 64'd10, 1'b1, 1'b0);
    chk("15+10+1", {cout, s}, 65'd26);
    apply(ONES, 64'd1, 1'b0, 1'b0);
    chk("ones+1", {cout, s}, 65'h1_0000_0000_0000_0000);
    apply(ONES, 64'd1, 1'b1, 1'b0);
    chk("ones+1+1", {cout, s}, 65'h1_0000_0000_0000_0001);
    apply(ONES, 64'd0, 1'b1, 1'b0);
    chk("ones+0+1", {cout, s}, 65'h1_0000_0000_0000_0000);
    apply(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
    chk("mix", {cout, s}, 65'h1_1111_1111_1111_1100);
    apply(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    chk("mix+1", {cout, s}, 65'h1_1111_1111_1111_1101);
    apply(64'h0, 64'h0, 1'b0, 1'b0);
    chk("zero", {cout, s}, 65'h0);
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    chk("msb+msb", {cout, s}, 65'h1_0000_0000_0000_0000);
    apply(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0);
    chk("alt+1", {cout, s}, 65'h1_0000_0000_0000_0000);
    apply(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("half", {cout, s}, 65'h0_0000_0001_0000_0000);

    // Reset mid-stream with operands that would otherwise give a large result.
    apply(ONES, ONES, 1'b1, 1'b1);
    chk("rst_mid", {cout, s}, 65'h0);
    apply(ONES, ONES, 1'b1, 1'b0);
    chk("after_rst", {cout, s}, 65'h1_FFFF_FFFF_FFFF_FFFF);

    // Narrow instance directed edges.
    apply8(8'hFF, 8'h01, 1'b0);
    chk("n8_wrap", {56'h0, cout8, s8}, 65'h100);
    apply8(8'hFF, 8'h00, 1'b1);
    chk("n8_wrap_cin", {56'h0, cout8, s8}, 65'h100);
    apply8(8'h0F, 8'h0A, 1'b1);
    chk("n8_small", {56'h0, cout8, s8}, 65'h01A);
    apply8(8'hFF, 8'hFF, 1'b1);
    chk("n8_max", {56'h0, cout8, s8}, 65'h1FF);

    // Back-to-back random operands on both widths.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rst  = 1'b0;
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      cin  = 1'($urandom_range(0, 1));
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, a} + {1'b0, b} + {64'h0, cin});
      exp8_q.push_back({1'b0, a8} + {1'b0, b8} + {8'h0, cin8});
      @(posedge clk);
      #1;
      chk("rand64", {cout, s}, exp_q.pop_front());
      chk("rand8", {56'h0, cout8, s8}, {56'h0, exp8_q.pop_front()});
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
